// File: rtl/alu_iter.sv
// Handshaked ALU: opcodes 0-10 single-cycle, MUL/MULHU (and DIVU/REMU when ALU_DIV_EN is defined) iterate one bit per cycle.
// Latency 1 for single-cycle ops, WIDTH+1 for iterative ops; divide by zero resolves in 1 cycle.
// Backpressure: result held in DONE until out_ready; in_ready low during RUN and while a result waits.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_data,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       op_q, op_nxt;
    logic [WIDTH-1:0] opb_q, opb_nxt;
    logic [WIDTH-1:0] acc_q, acc_nxt;
    logic [WIDTH-1:0] lo_q, lo_nxt;
    logic [SHW-1:0]   cnt_q, cnt_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic [WIDTH-1:0] quick;
    logic [WIDTH-1:0] step_acc, step_lo, final_res;
    logic [WIDTH:0]   mul_sum;
    logic [SHW-1:0]   shamt;
    logic             accept, long_op;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign accept    = in_valid && in_ready;
    assign shamt     = operand_b[SHW-1:0];

    always_comb begin
        quick = '0;
        case (alu_op)
            4'd0:  quick = operand_a + operand_b;
            4'd1:  quick = operand_a - operand_b;
            4'd2:  quick = operand_a << shamt;
            4'd3:  quick = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            4'd4:  quick = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
            4'd5:  quick = operand_a ^ operand_b;
            4'd6:  quick = operand_a >> shamt;
            4'd7:  quick = WIDTH'($signed(operand_a) >>> shamt);
            4'd8:  quick = operand_a | operand_b;
            4'd9:  quick = operand_a & operand_b;
            4'd10: quick = operand_b;
`ifdef ALU_DIV_EN
            // Only reached as a single-cycle result when the divisor is zero.
            4'd13: quick = '1;
            4'd14: quick = operand_a;
`endif
            default: quick = '0;
        endcase
    end

    always_comb begin
        long_op = (alu_op == 4'd11) || (alu_op == 4'd12);
`ifdef ALU_DIV_EN
        if (((alu_op == 4'd13) || (alu_op == 4'd14)) && (operand_b != '0))
            long_op = 1'b1;
`endif
    end

    // One iteration: acc holds the running high half (or remainder), lo the low half (or quotient).
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        step_acc = mul_sum[WIDTH:1];
        step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        if ((op_q == 4'd13) || (op_q == 4'd14)) begin
            logic [WIDTH:0] sh, diff;
            sh   = {acc_q, lo_q[WIDTH-1]};
            diff = sh - {1'b0, opb_q};
            if (sh >= {1'b0, opb_q}) begin
                step_acc = diff[WIDTH-1:0];
                step_lo  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = sh[WIDTH-1:0];
                step_lo  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
        final_res = ((op_q == 4'd11) || (op_q == 4'd13)) ? step_lo : step_acc;
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        opb_nxt   = opb_q;
        acc_nxt   = acc_q;
        lo_nxt    = lo_q;
        cnt_nxt   = cnt_q;
        data_nxt  = alu_data;
        case (state)
            RUN: begin
                acc_nxt = step_acc;
                lo_nxt  = step_lo;
                cnt_nxt = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_nxt = DONE;
                    data_nxt  = final_res;
                end
            end
            default: begin
                if (accept) begin
                    op_nxt  = alu_op;
                    opb_nxt = operand_b;
                    if (long_op) begin
                        state_nxt = RUN;
                        acc_nxt   = '0;
                        lo_nxt    = operand_a;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = DONE;
                        data_nxt  = quick;
                    end
                end else if ((state == DONE) && out_ready) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            alu_data <= '0;
        end else begin
            state    <= state_nxt;
            op_q     <= op_nxt;
            opb_q    <= opb_nxt;
            acc_q    <= acc_nxt;
            lo_q     <= lo_nxt;
            cnt_q    <= cnt_nxt;
            alu_data <= data_nxt;
        end
    end
endmodule
